// File: rtl/dcache_miss_handler_pkg.sv
// Shared types and geometry for the data-cache miss handler and the cache arrays it fills.
package dcache_miss_handler_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int LINE_WORDS  = 4;
    localparam int INDEX_BITS  = 6;
    localparam int WORD_BITS   = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * 4);
    localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_BITS   = LINE_WORDS * DATA_WIDTH;

    typedef enum logic [2:0] {
        MS_IDLE,
        MS_MISS,
        MS_REQ,
        MS_WAIT,
        MS_FILL,
        MS_DONE
    } miss_state_e;

    typedef struct packed {
        logic [INDEX_BITS-1:0] index;
        logic [TAG_BITS-1:0]   tag;
        logic [LINE_BITS-1:0]  line;
    } fill_req_t;

    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
        line_base = {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_miss_handler_if.sv
// Lookup, memory-refill, status and array-fill signals of the miss handler.
// Handshake: mem_req stays high with a stable mem_addr until a cycle with mem_gnt=1; mem_rvalid beats carry no backpressure.
interface dcache_miss_handler_if;
    import dcache_miss_handler_pkg::*;

    logic                  lookup_valid;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  lookup_hit;
    logic                  kill;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  data_missed1;
    logic                  data_busy;
    logic                  data_finished1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  fill_valid;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [LINE_BITS-1:0]  fill_line;

    modport slave (
        input  lookup_valid, lookup_addr, lookup_hit, kill, mem_gnt, mem_rvalid, mem_rdata,
        output mem_req, mem_addr, data_missed1, data_busy, data_finished1, data_out,
               fill_valid, fill_index, fill_tag, fill_line
    );

    modport master (
        output lookup_valid, lookup_addr, lookup_hit, kill, mem_gnt, mem_rvalid, mem_rdata,
        input  mem_req, mem_addr, data_missed1, data_busy, data_finished1, data_out,
               fill_valid, fill_index, fill_tag, fill_line
    );

endinterface

// File: rtl/dcache_miss_handler_refill_buffer.sv
// Line-sized beat collector: one write port per refill beat, a word-select read and the flat line.
module refill_buffer
    import dcache_miss_handler_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WORD_BITS-1:0]  wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [WORD_BITS-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LINE_BITS-1:0]  line
);

    logic [DATA_WIDTH-1:0] words_q [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else if (wr_en) begin
            words_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = words_q[rd_idx];

    // Word 0 lands in the least significant bits of the line.
    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line[i*DATA_WIDTH +: DATA_WIDTH] = words_q[i];
        end
    end

endmodule

// File: rtl/dcache_miss_handler.sv
// Data-cache miss controller: requests the missing line, collects the beats, writes the fill
// and returns the requested word, driving the stall status seen by the hazard unit.
module dcache_miss_handler
    import dcache_miss_handler_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    dcache_miss_handler_if.slave       bus,
    output miss_state_e                dbg_state
);

    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

    miss_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_BITS-1:0]  cnt_q, cnt_d;
    logic                  squash_q, squash_d;
    logic                  beat_we;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [LINE_BITS-1:0]  line_flat;
    fill_req_t             fill_d;

    refill_buffer u_refill_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (beat_we),
        .wr_idx  (cnt_q),
        .wr_data (bus.mem_rdata),
        .rd_idx  (addr_q[OFFSET_BITS-1:2]),
        .rd_data (rd_word),
        .line    (line_flat)
    );

    assign fill_d.index = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign fill_d.tag   = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign fill_d.line  = line_flat;
    assign dbg_state    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MS_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            squash_q <= squash_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        cnt_d              = cnt_q;
        squash_d           = squash_q;
        beat_we            = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_addr       = '0;
        bus.data_missed1   = 1'b0;
        bus.data_busy      = 1'b0;
        bus.data_finished1 = 1'b0;
        bus.data_out       = '0;
        bus.fill_valid     = 1'b0;
        bus.fill_index     = '0;
        bus.fill_tag       = '0;
        bus.fill_line      = '0;

        unique case (state_q)
            MS_IDLE: begin
                squash_d = 1'b0;
                if (bus.lookup_valid && !bus.lookup_hit) begin
                    addr_d  = bus.lookup_addr;
                    state_d = MS_MISS;
                end
            end
            MS_MISS: begin
                bus.data_missed1 = 1'b1;
                state_d          = bus.kill ? MS_IDLE : MS_REQ;
            end
            MS_REQ: begin
                bus.data_busy = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_addr  = line_base(addr_q);
                // A grant wins over a same-cycle kill: the read is already committed.
                if (bus.mem_gnt) begin
                    state_d  = MS_WAIT;
                    cnt_d    = '0;
                    squash_d = bus.kill;
                end else if (bus.kill) begin
                    state_d = MS_IDLE;
                end
            end
            MS_WAIT: begin
                bus.data_busy = 1'b1;
                if (bus.kill) begin
                    squash_d = 1'b1;
                end
                if (bus.mem_rvalid) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = MS_FILL;
                    end
                end
            end
            MS_FILL: begin
                bus.data_busy  = 1'b1;
                bus.fill_valid = 1'b1;
                bus.fill_index = fill_d.index;
                bus.fill_tag   = fill_d.tag;
                bus.fill_line  = fill_d.line;
                // The line is still written after a kill; only the word return is dropped.
                state_d        = (squash_q || bus.kill) ? MS_IDLE : MS_DONE;
                squash_d       = 1'b0;
            end
            MS_DONE: begin
                bus.data_finished1 = 1'b1;
                bus.data_out       = rd_word;
                state_d            = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Scenario bench for dcache_miss_handler: each task drives one situation and checks the
// observed pulses, fill and returned word against timing and data derived from the miss rules.
module tb_dcache_miss_handler;
  import dcache_miss_handler_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  miss_state_e dbg_state;

  dcache_miss_handler_if bus();

  dcache_miss_handler dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_WIDTH-1:0] exp_q[$];

  // per-transaction observation log
  int cyc_n, missed_n, missed_at, busy_n, busy_first, busy_last, req_n, req_addr_err;
  int excl_err, fill_n, fill_at, fin_n, fin_at;
  logic [INDEX_BITS-1:0] fill_idx_obs;
  logic [TAG_BITS-1:0]   fill_tag_obs;
  logic [LINE_BITS-1:0]  fill_line_obs;
  logic [DATA_WIDTH-1:0] fin_data;
  logic [ADDR_WIDTH-1:0] exp_req_addr;
  logic                  prev_fill;
  miss_state_e           post_fill_state;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic any_out();
    return |{bus.mem_req, bus.mem_addr, bus.data_missed1, bus.data_busy, bus.data_finished1,
             bus.data_out, bus.fill_valid, bus.fill_index, bus.fill_tag, bus.fill_line};
  endfunction

  task automatic drive_idle();
    bus.lookup_valid = 1'b0;
    bus.lookup_hit   = 1'b0;
    bus.kill         = 1'b0;
    bus.mem_gnt      = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = '0;
  endtask

  task automatic clear_log();
    cyc_n = 0; missed_n = 0; missed_at = -1; busy_n = 0; busy_first = -1; busy_last = -1;
    req_n = 0; req_addr_err = 0; excl_err = 0; fill_n = 0; fill_at = -1; fin_n = 0; fin_at = -1;
    prev_fill = 1'b0; post_fill_state = MS_MISS;
  endtask

  // Advance to the next falling edge and log what the DUT shows in that cycle.
  task automatic tick();
    @(negedge clk);
    cyc_n++;
    if (bus.data_missed1 === 1'b1) begin missed_n++; missed_at = cyc_n; end
    if (bus.data_busy === 1'b1) begin
      busy_n++;
      if (busy_first < 0) busy_first = cyc_n;
      busy_last = cyc_n;
    end
    if (bus.mem_req === 1'b1) begin
      req_n++;
      if (bus.mem_addr !== exp_req_addr) req_addr_err++;
    end
    if (int'(bus.data_missed1 === 1'b1) + int'(bus.data_busy === 1'b1)
        + int'(bus.data_finished1 === 1'b1) > 1) excl_err++;
    if (prev_fill) post_fill_state = dbg_state;
    prev_fill = (bus.fill_valid === 1'b1);
    if (bus.fill_valid === 1'b1) begin
      fill_n++; fill_at = cyc_n;
      fill_idx_obs = bus.fill_index; fill_tag_obs = bus.fill_tag; fill_line_obs = bus.fill_line;
    end
    if (bus.data_finished1 === 1'b1) begin fin_n++; fin_at = cyc_n; fin_data = bus.data_out; end
  endtask

  // One miss from acceptance to idle. kill_mode: 0 none, 1 kill in REQ before grant
  // (on the kill_req-th request cycle), 2 kill in WAIT after the second beat.
  task automatic miss_txn(input logic [ADDR_WIDTH-1:0] addr, input int gnt_delay, input int gap,
                          input int kill_mode, input int kill_req, input bit noise,
                          input bit fixed_beats, input string name);
    logic [DATA_WIDTH-1:0] beats [LINE_WORDS];
    logic [LINE_BITS-1:0]  exp_line;
    logic [DATA_WIDTH-1:0] exp_word;
    int fill_exp, budget, req_seen, beat_i, gap_cnt, kill_cyc;
    bit granted, killed, kill_pending;
    miss_state_e post_kill_state;

    for (int i = 0; i < LINE_WORDS; i++)
      beats[i] = fixed_beats ? DATA_WIDTH'(32'hA0 + i) : DATA_WIDTH'($urandom);
    for (int i = 0; i < LINE_WORDS; i++) exp_line[i*DATA_WIDTH +: DATA_WIDTH] = beats[i];
    fill_exp = 4 + gnt_delay + (LINE_WORDS - 1) * (gap + 1);
    budget   = fill_exp + 5;
    if (kill_mode == 0) exp_q.push_back(beats[(addr >> 2) % LINE_WORDS]);

    clear_log();
    exp_req_addr = (addr / (LINE_WORDS * 4)) * (LINE_WORDS * 4);
    granted = 0; killed = 0; kill_pending = 0; req_seen = 0; beat_i = 0; gap_cnt = 0;
    kill_cyc = -10; post_kill_state = MS_MISS;

    drive_idle();
    bus.lookup_valid = 1'b1;
    bus.lookup_addr  = addr;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (killed && cyc_n == kill_cyc + 1) post_kill_state = dbg_state;
      drive_idle();
      if (noise && cyc_n < fill_exp) begin
        bus.lookup_valid = 1'($urandom_range(0, 1));
        bus.lookup_addr  = $urandom;
        bus.lookup_hit   = 1'($urandom_range(0, 1));
      end
      if (kill_pending) begin bus.kill = 1'b1; kill_pending = 0; end
      if (bus.mem_req === 1'b1 && !granted && !killed) begin
        if (kill_mode == 1 && req_seen == kill_req) begin
          bus.kill = 1'b1; killed = 1; kill_cyc = cyc_n;
        end else if (kill_mode != 1 && req_seen == gnt_delay) begin
          bus.mem_gnt = 1'b1; granted = 1; gap_cnt = 0;
        end
        req_seen++;
      end else if (granted && beat_i < LINE_WORDS) begin
        if (gap_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = beats[beat_i];
          beat_i++;
          gap_cnt = gap;
          if (kill_mode == 2 && beat_i == 2) kill_pending = 1;
        end else begin
          gap_cnt--;
        end
      end
    end
    drive_idle();

    tests_run++;
    if (missed_n != 1 || missed_at != 1) begin
      tests_failed++;
      $display("FAIL %s missed1: got count %0d at %0d, want 1 at 1", name, missed_n, missed_at);
    end
    tests_run++;
    if (excl_err != 0) begin
      tests_failed++;
      $display("FAIL %s exclusive: %0d cycles with >1 status high, want 0", name, excl_err);
    end
    tests_run++;
    if (req_addr_err != 0) begin
      tests_failed++;
      $display("FAIL %s mem_addr: %0d request cycles off %h", name, req_addr_err, exp_req_addr);
    end

    if (kill_mode == 1) begin
      tests_run++;
      if (req_n != kill_req + 1 || busy_n != kill_req + 1) begin
        tests_failed++;
        $display("FAIL %s kill_req: req %0d busy %0d cycles, want %0d", name, req_n, busy_n, kill_req + 1);
      end
      tests_run++;
      if (fill_n != 0 || fin_n != 0 || post_kill_state !== MS_IDLE) begin
        tests_failed++;
        $display("FAIL %s kill_req_end: fill %0d fin %0d state %0d, want 0 0 %0d",
                 name, fill_n, fin_n, post_kill_state, MS_IDLE);
      end
    end else begin
      tests_run++;
      if (req_n != gnt_delay + 1) begin
        tests_failed++;
        $display("FAIL %s req_cycles: got %0d want %0d", name, req_n, gnt_delay + 1);
      end
      tests_run++;
      if (busy_first != 2 || busy_last != fill_exp || busy_n != fill_exp - 1) begin
        tests_failed++;
        $display("FAIL %s busy: got %0d..%0d (%0d), want 2..%0d (%0d)",
                 name, busy_first, busy_last, busy_n, fill_exp, fill_exp - 1);
      end
      tests_run++;
      if (fill_n != 1 || fill_at != fill_exp) begin
        tests_failed++;
        $display("FAIL %s fill_time: got %0d at %0d, want 1 at %0d", name, fill_n, fill_at, fill_exp);
      end
      tests_run++;
      if (fill_idx_obs !== INDEX_BITS'((addr >> 4) % 64) || fill_tag_obs !== TAG_BITS'(addr >> 10)) begin
        tests_failed++;
        $display("FAIL %s fill_idx_tag: got %h/%h want %h/%h", name, fill_idx_obs, fill_tag_obs,
                 INDEX_BITS'((addr >> 4) % 64), TAG_BITS'(addr >> 10));
      end
      tests_run++;
      if (fill_line_obs !== exp_line) begin
        tests_failed++;
        $display("FAIL %s fill_line: got %h want %h", name, fill_line_obs, exp_line);
      end
      if (kill_mode == 2) begin
        tests_run++;
        if (fin_n != 0 || post_fill_state !== MS_IDLE) begin
          tests_failed++;
          $display("FAIL %s kill_wait: fin %0d state after fill %0d, want 0 %0d",
                   name, fin_n, post_fill_state, MS_IDLE);
        end
      end else begin
        tests_run++;
        if (fin_n != 1 || fin_at != fill_exp + 1) begin
          tests_failed++;
          $display("FAIL %s finished1: got %0d at %0d, want 1 at %0d", name, fin_n, fin_at, fill_exp + 1);
        end
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        tests_run++;
        if (fin_data !== exp_word) begin
          tests_failed++;
          $display("FAIL %s data_out: got %h want %h", name, fin_data, exp_word);
        end
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    bus.lookup_addr = '0;
    reset = 1'b1;
    tick(); tick();
    tests_run++;
    if (dbg_state !== MS_IDLE || any_out() !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: state %0d outputs_nonzero %b, want %0d 0", dbg_state, any_out(), MS_IDLE);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (any_out() !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: outputs_nonzero %b want 0", any_out());
    end
  endtask

  task automatic test_basic();
    miss_txn(32'h0000_1234, 0, 0, 0, 0, 0, 1, "basic");
  endtask

  task automatic test_hit_ignored();
    clear_log();
    exp_req_addr = '0;
    for (int i = 0; i < 6; i++) begin
      bus.lookup_valid = 1'b1;
      bus.lookup_hit   = 1'b1;
      bus.lookup_addr  = $urandom;
      tick();
    end
    drive_idle();
    tick(); tick();
    tests_run++;
    if (missed_n + busy_n + fin_n + req_n + fill_n != 0) begin
      tests_failed++;
      $display("FAIL hit_ignored: missed %0d busy %0d fin %0d req %0d fill %0d, want all 0",
               missed_n, busy_n, fin_n, req_n, fill_n);
    end
  endtask

  task automatic test_delayed_grant();
    miss_txn($urandom, 5, 2, 0, 0, 0, 0, "delayed_grant");
  endtask

  task automatic test_kill_req();
    miss_txn($urandom, 8, 0, 1, 1, 0, 0, "kill_req");
    tick();
  endtask

  task automatic test_kill_wait();
    miss_txn($urandom, 1, 1, 2, 0, 0, 0, "kill_wait");
  endtask

  task automatic test_reset_mid_wait();
    clear_log();
    exp_req_addr = 32'h0000_8760;
    drive_idle();
    bus.lookup_valid = 1'b1;
    bus.lookup_addr  = 32'h0000_876C;
    tick();
    bus.lookup_valid = 1'b0;
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
    tick();
    bus.mem_rdata = $urandom;
    tick();
    bus.mem_rvalid = 1'b0;
    tests_run++;
    if (bus.data_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_busy: data_busy %b want 1", bus.data_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (dbg_state !== MS_IDLE || any_out() !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: state %0d outputs_nonzero %b, want %0d 0", dbg_state, any_out(), MS_IDLE);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    drive_idle();
    tick();
    tests_run++;
    if (any_out() !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_stale_beat: outputs_nonzero %b want 0", any_out());
    end
    miss_txn($urandom, 0, 0, 0, 0, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      miss_txn($urandom, $urandom_range(0, 4), $urandom_range(0, 2), 0, 0, 1, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    miss_txn($urandom, 0, 0, 0, 0, 0, 0, "b2b_first");
    miss_txn($urandom, 0, 0, 0, 0, 0, 0, "b2b_second");
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    bus.lookup_addr = '0;
    test_reset();
    test_basic();
    test_hit_ignored();
    test_delayed_grant();
    test_kill_req();
    test_kill_wait();
    test_reset_mid_wait();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dcache_miss_handler.md
Name: dcache_miss_handler

Overview:
- Data-cache miss controller. Consumes load/store lookups and tag-compare results from the memory stage.
- On a miss, it fetches the line from memory, writes the fill into the data/tag arrays and returns the requested word.
- It is the source of the data_missed1, data_busy and data_finished1 status signals that the hazard unit turns into backend_stall.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width and memory beat width.
- LINE_WORDS, 4, words per cache line (power of two, ≥2).
- INDEX_BITS, 6, cache set-index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- lookup_valid  in  1  memory stage presents an access this cycle.
- lookup_addr  in  ADDR_WIDTH  byte address of the access.
- lookup_hit  in  1  same-cycle tag-compare result for lookup_addr.
- kill  in  1  squash the in-flight miss (branch mispredict flush).
- mem_req  out  1  line-read request to memory.
- mem_addr  out  ADDR_WIDTH  line-aligned request address.
- mem_gnt  in  1  memory accepts the request.
- mem_rvalid  in  1  refill beat valid.
- mem_rdata  in  DATA_WIDTH  refill beat, ascending word order from the line base.
- data_missed1  out  1  one-cycle pulse: miss accepted.
- data_busy  out  1  refill in progress.
- data_finished1  out  1  one-cycle pulse: requested word available.
- data_out  out  DATA_WIDTH  requested word; valid only while data_finished1=1.
- fill_valid  out  1  one-cycle array write strobe.
- fill_index  out  INDEX_BITS  set being filled.
- fill_tag  out  ADDR_WIDTH-INDEX_BITS-log2(LINE_WORDS*4)  tag written with the fill.
- fill_line  out  LINE_WORDS*DATA_WIDTH  line data; word 0 in the LSBs.

Behaviour:
- Reset: state IDLE; beat counter=0; squash flag=0. All outputs are 0, including mem_addr, data_out, fill_* and the fill buffer.
- States: IDLE → MISS → REQ → WAIT → FILL → DONE → IDLE.
  - IDLE: a miss is accepted when lookup_valid && !lookup_hit. The block latches the address and goes to MISS. Hits, and any lookups in non-IDLE states, are ignored.
  - MISS (1 cycle): data_missed1=1, data_busy=0. Next state is REQ.
  - REQ: mem_req=1 and mem_addr = latched address with its low log2(LINE_WORDS*4) bits zeroed. mem_req is held until mem_gnt. On mem_gnt the block goes to WAIT with the counter at 0.
  - WAIT: each mem_rvalid stores mem_rdata into buffer[counter], then counter++. After the beat with counter==LINE_WORDS-1, the block goes to FILL. Gaps between beats are permitted.
  - FILL (1 cycle): fill_valid=1 with index, tag and buffer contents. Next state is DONE.
  - DONE (1 cycle): data_finished1=1 and data_out = buffer[latched word offset]. Next state is IDLE.
- data_busy=1 in REQ, WAIT and FILL.
- Status-signal exclusivity: at most one of data_missed1 / data_busy / data_finished1 is high in any cycle. At least one is high in every non-IDLE cycle, so the backend never unstalls mid-miss.
- Minimum latency, acceptance to data_finished1 (mem_gnt the same cycle as mem_req, back-to-back beats): LINE_WORDS+4 cycles.
- kill:
  - In MISS or REQ before grant: return to IDLE next cycle with no memory request issued. A request granted in the same cycle as kill counts as after grant.
  - In WAIT, FILL or after grant: set the squash flag. Beats are still drained and the fill is still written (the line is valid memory data). DONE is skipped and data_finished1 is suppressed; the block goes FILL → IDLE.
  - In IDLE: no effect.
- A beat arriving on mem_rvalid outside WAIT is ignored. Memory guarantees this does not happen.
- Counter width is log2(LINE_WORDS); it wraps to 0 on FILL entry.
- Reset mid-operation: immediate IDLE, all outputs 0. Stale beats afterwards are ignored.

Decomposition:
- Shared package holds:
  - LINE_WORDS, INDEX_BITS and the derived offset/tag widths;
  - the MissState enum;
  - a FillReq struct {index, tag, line}, so the cache array uses the same type.
- One natural sub-module, `refill_buffer`: LINE_WORDS×DATA_WIDTH registers, beat write port, word-select read port and flat line output. The FSM remains in the top module.

Test Plan:
- Miss at 0x0000_1234, grant immediate, beats 0xA0..0xA3 back-to-back:
  - data_missed1 at T+1; data_busy T+2..T+7; fill_valid at T+7 with index 0x23 and line {0xA3,0xA2,0xA1,0xA0}.
  - data_finished1 at T+8 with data_out=0xA1 (word offset 1).
- Hit lookup (lookup_hit=1) in IDLE → no pulses, mem_req stays 0.
- Grant delayed 5 cycles, beats with 2-cycle gaps → mem_req held steady with the same mem_addr; the buffer collects correct words; data_busy continuous with no gap cycle.
- kill during REQ before grant → IDLE next cycle, mem_req drops, no fill_valid, no data_finished1.
- kill during WAIT after beat 1 → remaining beats drained, fill_valid asserted, data_finished1 never asserted, IDLE the cycle after FILL.
- reset asserted during WAIT → all outputs 0 next cycle; a new miss after reset completes normally with correct data.
